// File: rtl/orion_decoup_pkg.sv
// Shared types and sizing helpers for the Orion 2-phase decoupling FIFO.
// Latency: none, constant functions and types only.
// Backpressure: none, no logic here.
package orion_decoup_pkg;

    typedef struct packed {
        logic req;
        logic ack;
    } hs_t;

    // Pointer needs at least one bit even when DEPTH == 1.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // A 2-phase pair has an outstanding token whenever its two wires differ.
    function automatic logic hs_pending(input hs_t hs);
        return hs.req ^ hs.ack;
    endfunction

endpackage

// File: rtl/orion_sync2.sv
// Two-flop synchronizer for a single handshake wire, reset to a chosen level.
// Latency: 2 clock edges from d to q.
// Backpressure: none, it is a plain delay line.
module orion_sync2
    import orion_decoup_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/orion_decoup_fifo_2ph.sv
// DEPTH-entry clocked FIFO between 2-phase bundled-data handshakes; ORION_DECOUP_SYNC_EN adds input synchronizers.
// Latency: in_ack toggles on the edge that sees in_req, out_req one edge later at the earliest (+2 per leg when synced).
// Backpressure: when full, in_ack holds and in_data is ignored; launches wait until out_ack matches out_req.
module orion_decoup_fifo_2ph
    import orion_decoup_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] D_INIT  = '0,
    parameter logic             PI_INIT = 1'b0,
    parameter logic             PO_INIT = 1'b0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_req,
    output logic                      in_ack,
    input  logic [WIDTH-1:0]          in_data,
    output logic                      out_req,
    input  logic                      out_ack,
    output logic [WIDTH-1:0]          out_data,
    output logic [cnt_w(DEPTH)-1:0]   count
);

    localparam int              PW   = ptr_w(DEPTH);
    localparam int              CW   = cnt_w(DEPTH);
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);
    localparam logic [PW-1:0]   LAST = PW'(DEPTH - 1);

    logic             req_s;
    logic             ack_s;
    hs_t              in_hs;
    hs_t              out_hs;
    logic             push;
    logic             launch;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

`ifdef ORION_DECOUP_SYNC_EN
    orion_sync2 #(.RST_VAL(PI_INIT)) u_sync_req (
        .clock (clock),
        .reset (reset),
        .d     (in_req),
        .q     (req_s)
    );

    orion_sync2 #(.RST_VAL(PO_INIT)) u_sync_ack (
        .clock (clock),
        .reset (reset),
        .d     (out_ack),
        .q     (ack_s)
    );
`else
    assign req_s = in_req;
    assign ack_s = out_ack;
`endif

    assign in_hs  = '{req: req_s,   ack: in_ack};
    assign out_hs = '{req: out_req, ack: ack_s};

    // No bypass: a launch only ever reads an entry stored on an earlier edge.
    assign push   = hs_pending(in_hs) && (count != FULL);
    assign launch = !hs_pending(out_hs) && (count != '0);

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ack   <= PI_INIT;
            out_req  <= PO_INIT;
            out_data <= D_INIT;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
                in_ack <= ~in_ack;
            end
            if (launch) begin
                rd_ptr   <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
                out_data <= mem[rd_ptr];
                out_req  <= ~out_req;
            end
            case ({push, launch})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_orion_decoup_fifo_2ph.sv
// Directed bench: DEPTH=4 instance for the main flow, DEPTH=3 instance for wrap, PI_INIT/PO_INIT tokens at reset.
module tb_orion_decoup_fifo_2ph;

`ifdef ORION_DECOUP_SYNC_EN
    localparam int L = 3;
`else
    localparam int L = 1;
`endif

    logic       clock = 1'b0;
    logic       reset;

    logic       in_req, in_ack, out_req, out_ack;
    logic [7:0] in_data, out_data;
    logic [2:0] count;

    logic       in_req3, in_ack3, out_req3, out_ack3;
    logic [7:0] in_data3, out_data3;
    logic [1:0] count3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    orion_decoup_fifo_2ph #(
        .WIDTH(8), .DEPTH(4), .D_INIT(8'h5A), .PI_INIT(1'b0), .PO_INIT(1'b0)
    ) dut (
        .clock(clock), .reset(reset),
        .in_req(in_req), .in_ack(in_ack), .in_data(in_data),
        .out_req(out_req), .out_ack(out_ack), .out_data(out_data),
        .count(count)
    );

    orion_decoup_fifo_2ph #(
        .WIDTH(8), .DEPTH(3), .D_INIT(8'h3C), .PI_INIT(1'b1), .PO_INIT(1'b1)
    ) dut3 (
        .clock(clock), .reset(reset),
        .in_req(in_req3), .in_ack(in_ack3), .in_data(in_data3),
        .out_req(out_req3), .out_ack(out_ack3), .out_data(out_data3),
        .count(count3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic send(input logic [7:0] d);
        in_data = d;
        in_req  = !in_req;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (in_ack == in_req) break;
        end
        chk("send_ack", in_ack, in_req);
    endtask

    task automatic wait_launch();
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (out_req != out_ack) break;
        end
        chk("launch", out_req, !out_ack);
    endtask

    task automatic take(input logic [7:0] exp);
        out_ack = out_req;
        wait_launch();
        chk("take_data", out_data, exp);
    endtask

    task automatic send3(input logic [7:0] d);
        in_data3 = d;
        in_req3  = !in_req3;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (in_ack3 == in_req3) break;
        end
        chk("send3_ack", in_ack3, in_req3);
    endtask

    task automatic wait_launch3();
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (out_req3 != out_ack3) break;
        end
        chk("launch3", out_req3, !out_ack3);
    endtask

    task automatic take3(input logic [7:0] exp);
        out_ack3 = out_req3;
        wait_launch3();
        chk("take3_data", out_data3, exp);
    endtask

    initial begin
        reset    = 1'b1;
        in_req   = 1'b0;
        out_ack  = 1'b0;
        in_data  = 8'h00;
        in_req3  = 1'b0;
        out_ack3 = 1'b1;
        in_data3 = 8'h77;

        // Reset state of both instances.
        repeat (3) cyc();
        chk("rst_in_ack", in_ack, 1'b0);
        chk("rst_out_req", out_req, 1'b0);
        chk("rst_out_data", out_data, 8'h5A);
        chk("rst_count", count, 3'd0);
        chk("rst3_in_ack", in_ack3, 1'b1);
        chk("rst3_out_req", out_req3, 1'b1);
        chk("rst3_out_data", out_data3, 8'h3C);
        reset = 1'b0;

        // dut stays quiet; dut3 takes the token left pending by in_req3 != PI_INIT.
        for (int i = 1; i <= 10; i++) begin
            cyc();
            chk("idle_in_ack", in_ack, 1'b0);
            chk("idle_out_req", out_req, 1'b0);
            chk("idle_count", count, 3'd0);
            chk("pend3_in_ack", in_ack3, (i < L));
            chk("pend3_out_req", out_req3, (i < L + 1));
            chk("pend3_out_data", out_data3, (i > L) ? 8'h77 : 8'h3C);
            chk("pend3_count", count3, (i == L));
        end

        // Single token with exact edge timing.
        in_data = 8'hA5;
        in_req  = 1'b1;
        for (int j = 1; j <= L + 1; j++) begin
            cyc();
            chk("single_in_ack", in_ack, (j >= L));
            chk("single_out_req", out_req, (j >= L + 1));
            chk("single_count", count, (j == L));
            chk("single_out_data", out_data, (j >= L + 1) ? 8'hA5 : 8'h5A);
        end
        out_ack = 1'b1;
        repeat (L + 1) cyc();
        chk("single_drained", count, 3'd0);
        chk("single_hold_req", out_req, 1'b1);

        // Fill with out_ack held: 0x01 launches, 0x02..0x05 fill.
        for (int k = 1; k <= 5; k++) send(8'(k));
        repeat (2) cyc();
        chk("fill_count", count, 3'd4);
        chk("fill_out_data", out_data, 8'h01);
        chk("fill_out_req", out_req, 1'b0);

        // Sixth token stalls while full.
        in_data = 8'h06;
        in_req  = !in_req;
        repeat (6) cyc();
        chk("stall_in_ack", in_ack, !in_req);
        chk("stall_count", count, 3'd4);

        // Ack frees a slot: launch 0x02, then 0x06 accepted one edge later.
        out_ack = out_req;
        for (int j = 1; j <= L + 1; j++) begin
            cyc();
            chk("free_out_req", out_req, (j >= L));
            chk("free_out_data", out_data, (j >= L) ? 8'h02 : 8'h01);
            chk("free_count", count, (j == L) ? 3'd3 : 3'd4);
            chk("free_in_ack", in_ack, (j > L));
        end
        take(8'h03);
        take(8'h04);
        take(8'h05);
        take(8'h06);
        chk("fill_empty", count, 3'd0);

        // Same-edge push and launch at count=2.
        send(8'h11);
        send(8'h12);
        chk("simul_pre_count", count, 3'd2);
        in_data = 8'h13;
        in_req  = !in_req;
        out_ack = out_req;
        repeat (L) cyc();
        chk("simul_count", count, 3'd2);
        chk("simul_out_data", out_data, 8'h11);
        chk("simul_in_ack", in_ack, in_req);
        take(8'h12);
        take(8'h13);
        chk("simul_empty", count, 3'd0);

        // Wrap on the DEPTH=3 instance: 0x77 is still in flight.
        send3(8'h80);
        send3(8'h81);
        send3(8'h82);
        chk("wrap3_full", count3, 2'd3);
        for (int k = 0; k < 8; k++) begin
            take3(8'h80 + 8'(k));
            if (k + 3 < 8) send3(8'h83 + 8'(k));
        end
        chk("wrap3_empty", count3, 2'd0);

        // Reset mid-operation with count=3 and 0x13 in flight.
        send(8'h21);
        send(8'h22);
        send(8'h23);
        chk("mid_count", count, 3'd3);
        reset    = 1'b1;
        in_req   = 1'b0;
        out_ack  = 1'b0;
        in_req3  = 1'b1;
        out_ack3 = 1'b0;
        cyc();
        chk("mid_rst_count", count, 3'd0);
        chk("mid_rst_out_req", out_req, 1'b0);
        chk("mid_rst_out_data", out_data, 8'h5A);
        chk("mid_rst_in_ack", in_ack, 1'b0);
        chk("mid_rst3_count", count3, 2'd0);
        chk("mid_rst3_out_req", out_req3, 1'b1);
        cyc();
        reset = 1'b0;

        // Fresh token after reset.
        send(8'hC3);
        wait_launch();
        chk("fresh_out_data", out_data, 8'hC3);

        // dut3 came out of reset with a D_INIT token in flight: no launch until acked.
        send3(8'h99);
        repeat (4) cyc();
        chk("inflight3_out_req", out_req3, 1'b1);
        chk("inflight3_count", count3, 2'd1);
        chk("inflight3_out_data", out_data3, 8'h3C);
        out_ack3 = 1'b1;
        wait_launch3();
        chk("inflight3_data", out_data3, 8'h99);
        cyc();
        chk("inflight3_empty", count3, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
